// File: rtl/pll_ctl_pkg.sv
// pll_ctl_pkg
//   Shared definitions for the PLL lock controller slice.
//   - pll_state_t : sequencing states of pll_lock_ctl
//   - DEF_M0/N/P  : divider values driven at reset and held in the
//                   configuration shadow until software writes new ones
//   - sat_inc8    : 8-bit saturating increment used by the loss counter
package pll_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STBY_HOLD,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_LOST,
    ST_FAIL
  } pll_state_t;

  localparam logic DEF_M0 = 1'b1;
  localparam int   DEF_N  = 7;
  localparam int   DEF_P  = 1;

  // Counts up to 255 and then sticks there.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2
//   Two-flop synchroniser for a single asynchronous level signal.
//   Ports:
//     clk     : destination clock
//     reset_l : asynchronous active-low reset, clears both stages
//     d       : asynchronous input
//     q       : synchronised output, two clk edges behind d
module sync2 (
  input  logic clk,
  input  logic reset_l,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; only the second stage is used downstream.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctl.sv
// pll_lock_ctl
//   Sequences a PLL from standby through lock, switches the system clock
//   mux onto the PLL once lock is stable, and recovers from lock loss.
//   Ports:
//     clk, reset_l   : reference clock, asynchronous active-low reset
//     en             : enable sequencing; low forces IDLE
//     plock          : asynchronous PLL lock indicator
//     cfg_valid/ready: handshake for a new divider configuration
//     cfg_m0/n/p/chstby : configuration payload (captured into a shadow)
//     pll_stby       : PLL standby control
//     pll_m0/n/p/chstby : divider settings driven to the PLL
//                      (pll_chstby[0] is the feedback port, always active)
//     clk_sel        : 0 = bypass reference, 1 = PLL output
//     locked, fail   : status flags
//     lost           : one-cycle pulse on each loss of lock
//     lost_cnt       : saturating count of lock losses
module pll_lock_ctl
  import pll_ctl_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int DIV_W        = 4,
  parameter int STBY_CYCLES  = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int SETTLE       = 8,
  parameter int RETRY_MAX    = 3
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  en,
  input  logic                  plock,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_m0,
  input  logic [DIV_W-1:0]      cfg_n,
  input  logic [N_CH*DIV_W-1:0] cfg_p,
  input  logic [N_CH-1:0]       cfg_chstby,
  output logic                  pll_stby,
  output logic                  pll_m0,
  output logic [DIV_W-1:0]      pll_n,
  output logic [N_CH*DIV_W-1:0] pll_p,
  output logic [N_CH-1:0]       pll_chstby,
  output logic                  clk_sel,
  output logic                  locked,
  output logic                  fail,
  output logic                  lost,
  output logic [7:0]            lost_cnt
);

  localparam int SB_W = $clog2(STBY_CYCLES + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W = $clog2(SETTLE + 1);
  localparam int RT_W = $clog2(RETRY_MAX + 1);

  localparam logic [SB_W-1:0] SB_LAST = SB_W'(STBY_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RETRY_MAX - 1);

  localparam logic [DIV_W-1:0]      N_RST      = DIV_W'(DEF_N);
  localparam logic [DIV_W-1:0]      P_FIELD    = DIV_W'(DEF_P);
  localparam logic [N_CH*DIV_W-1:0] P_RST      = {N_CH{P_FIELD}};
  localparam logic [N_CH-1:0]       CH0_BIT    = N_CH'(1);
  localparam logic [N_CH-1:0]       CHSTBY_RST = ~CH0_BIT;

  pll_state_t              state;
  logic                    plock_s;
  logic                    cfg_fire;
  logic [SB_W-1:0]         stby_cnt;
  logic [TO_W-1:0]         timer;
  logic [ST_W-1:0]         settle;
  logic [RT_W-1:0]         retry;

  logic                    sh_m0;
  logic [DIV_W-1:0]        sh_n;
  logic [N_CH*DIV_W-1:0]   sh_p;
  logic [N_CH-1:0]         sh_chstby;

  assign cfg_fire = cfg_valid & cfg_ready;

  sync2 u_plock_sync (
    .clk     (clk),
    .reset_l (reset_l),
    .d       (plock),
    .q       (plock_s)
  );

  // Shadow of the last accepted configuration. It is decoupled from the
  // live divider outputs so a write while the PLL is running never
  // disturbs it; the PLL picks the shadow up at the next standby.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sh_m0     <= DEF_M0;
      sh_n      <= N_RST;
      sh_p      <= P_RST;
      sh_chstby <= {N_CH{1'b1}};
    end else if (cfg_fire) begin
      sh_m0     <= cfg_m0;
      sh_n      <= cfg_n;
      sh_p      <= cfg_p;
      sh_chstby <= cfg_chstby;
    end
  end

  // Sequencer. Every output is assigned here so that each one changes on
  // the same edge as the state it belongs to; in particular clk_sel and
  // locked can only rise on entry to RUN and fall on leaving it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= ST_IDLE;
      stby_cnt   <= '0;
      timer      <= '0;
      settle     <= '0;
      retry      <= '0;
      cfg_ready  <= 1'b1;
      pll_stby   <= 1'b1;
      pll_m0     <= DEF_M0;
      pll_n      <= N_RST;
      pll_p      <= P_RST;
      pll_chstby <= CHSTBY_RST;
      clk_sel    <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      lost       <= 1'b0;
      lost_cnt   <= 8'd0;
    end else begin
      lost <= 1'b0;
      if (!en) begin
        state     <= ST_IDLE;
        stby_cnt  <= '0;
        timer     <= '0;
        settle    <= '0;
        retry     <= '0;
        cfg_ready <= 1'b1;
        pll_stby  <= 1'b1;
        clk_sel   <= 1'b0;
        locked    <= 1'b0;
        fail      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_STBY_HOLD;
            stby_cnt  <= '0;
            cfg_ready <= 1'b0;
            pll_stby  <= 1'b1;
          end

          ST_STBY_HOLD: begin
            // Dividers only ever move here, with the PLL held in standby.
            if (stby_cnt == '0) begin
              pll_m0     <= sh_m0;
              pll_n      <= sh_n;
              pll_p      <= sh_p;
              pll_chstby <= sh_chstby & CHSTBY_RST;
            end
            if (stby_cnt == SB_LAST) begin
              state    <= ST_WAIT_LOCK;
              stby_cnt <= '0;
              timer    <= '0;
              settle   <= '0;
              pll_stby <= 1'b0;
            end else begin
              stby_cnt <= stby_cnt + SB_W'(1);
            end
          end

          ST_WAIT_LOCK: begin
            // Lock must be seen high for SETTLE consecutive cycles; any low
            // sample restarts the count, filtering lock glitches.
            if (plock_s && settle == ST_LAST) begin
              state     <= ST_RUN;
              settle    <= '0;
              timer     <= '0;
              retry     <= '0;
              cfg_ready <= 1'b1;
              clk_sel   <= 1'b1;
              locked    <= 1'b1;
            end else if (timer == TO_LAST) begin
              timer    <= '0;
              settle   <= '0;
              pll_stby <= 1'b1;
              if (retry == RT_LAST) begin
                state     <= ST_FAIL;
                cfg_ready <= 1'b1;
                fail      <= 1'b1;
              end else begin
                state    <= ST_STBY_HOLD;
                stby_cnt <= '0;
                retry    <= retry + RT_W'(1);
              end
            end else begin
              timer  <= timer + TO_W'(1);
              settle <= plock_s ? settle + ST_W'(1) : '0;
            end
          end

          ST_RUN: begin
            // A reconfiguration wins over a simultaneous loss: both end in
            // standby, and the relock uses the new dividers.
            if (cfg_fire) begin
              state     <= ST_STBY_HOLD;
              stby_cnt  <= '0;
              retry     <= '0;
              cfg_ready <= 1'b0;
              pll_stby  <= 1'b1;
              clk_sel   <= 1'b0;
              locked    <= 1'b0;
            end else if (!plock_s) begin
              state     <= ST_LOST;
              cfg_ready <= 1'b0;
              pll_stby  <= 1'b1;
              clk_sel   <= 1'b0;
              locked    <= 1'b0;
              lost      <= 1'b1;
              lost_cnt  <= sat_inc8(lost_cnt);
            end
          end

          ST_LOST: begin
            state    <= ST_STBY_HOLD;
            stby_cnt <= '0;
          end

          ST_FAIL: begin
            if (cfg_fire) begin
              state     <= ST_STBY_HOLD;
              stby_cnt  <= '0;
              retry     <= '0;
              cfg_ready <= 1'b0;
              fail      <= 1'b0;
            end
          end

          default: begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
            pll_stby  <= 1'b1;
            clk_sel   <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_ctl.sv
// tb_pll_lock_ctl
//   Directed bench for pll_lock_ctl. Stimulus pushes the expected lock,
//   loss and fail events (with the cycle they must appear on) into a
//   scoreboard queue; a monitor on the falling clock edge pops and compares
//   whenever the DUT raises locked or fail or pulses lost.
module tb_pll_lock_ctl;

  localparam int N_CH         = 3;
  localparam int DIV_W        = 4;
  localparam int STBY_CYCLES  = 4;
  localparam int LOCK_TIMEOUT = 16;
  localparam int SETTLE       = 3;
  localparam int RETRY_MAX    = 2;

  localparam int EV_LOCK = 0;
  localparam int EV_LOST = 1;
  localparam int EV_FAIL = 2;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } exp_t;

  exp_t sbQueue[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic                  clk;
  logic                  reset_l;
  logic                  en;
  logic                  plock;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_m0;
  logic [DIV_W-1:0]      cfg_n;
  logic [N_CH*DIV_W-1:0] cfg_p;
  logic [N_CH-1:0]       cfg_chstby;
  logic                  pll_stby;
  logic                  pll_m0;
  logic [DIV_W-1:0]      pll_n;
  logic [N_CH*DIV_W-1:0] pll_p;
  logic [N_CH-1:0]       pll_chstby;
  logic                  clk_sel;
  logic                  locked;
  logic                  fail;
  logic                  lost;
  logic [7:0]            lost_cnt;

  logic        prevLocked = 1'b0;
  logic        prevFail   = 1'b0;
  logic [19:0] prevDiv    = '0;

  pll_lock_ctl #(
    .N_CH         (N_CH),
    .DIV_W        (DIV_W),
    .STBY_CYCLES  (STBY_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE       (SETTLE),
    .RETRY_MAX    (RETRY_MAX)
  ) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .en         (en),
    .plock      (plock),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_m0     (cfg_m0),
    .cfg_n      (cfg_n),
    .cfg_p      (cfg_p),
    .cfg_chstby (cfg_chstby),
    .pll_stby   (pll_stby),
    .pll_m0     (pll_m0),
    .pll_n      (pll_n),
    .pll_p      (pll_p),
    .pll_chstby (pll_chstby),
    .clk_sel    (clk_sel),
    .locked     (locked),
    .fail       (fail),
    .lost       (lost),
    .lost_cnt   (lost_cnt)
  );

  // Free-running reference clock and a cycle stamp advanced on each rising
  // edge, so at a falling edge cyc names the edge that just happened.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic expectEvent(input int kind, input int atCyc, input int data);
    exp_t e;
    e.kind = kind;
    e.cyc  = atCyc;
    e.data = data;
    sbQueue.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // One configuration transfer; returns on the falling edge after the
  // edge that accepted it.
  task automatic applyStimulus(input logic m0, input logic [DIV_W-1:0] n,
                               input logic [N_CH*DIV_W-1:0] p,
                               input logic [N_CH-1:0] chs);
    cfg_m0     = m0;
    cfg_n      = n;
    cfg_p      = p;
    cfg_chstby = chs;
    cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_stby"},   pll_stby,   1);
    checkOutput({tag, "_pll_m0"},     pll_m0,     1);
    checkOutput({tag, "_pll_n"},      pll_n,      7);
    checkOutput({tag, "_pll_p"},      pll_p,      12'h111);
    checkOutput({tag, "_pll_chstby"}, pll_chstby, 3'b110);
    checkOutput({tag, "_clk_sel"},    clk_sel,    0);
    checkOutput({tag, "_locked"},     locked,     0);
    checkOutput({tag, "_fail"},       fail,       0);
    checkOutput({tag, "_lost"},       lost,       0);
    checkOutput({tag, "_lost_cnt"},   lost_cnt,   0);
    checkOutput({tag, "_cfg_ready"},  cfg_ready,  1);
  endtask

  task automatic monitorStep();
    int   kind;
    bit   seen;
    exp_t e;
    seen = 1'b0;
    kind = 0;
    if (lost === 1'b1) begin
      seen = 1'b1;
      kind = EV_LOST;
    end else if (locked === 1'b1 && prevLocked !== 1'b1) begin
      seen = 1'b1;
      kind = EV_LOCK;
    end else if (fail === 1'b1 && prevFail !== 1'b1) begin
      seen = 1'b1;
      kind = EV_FAIL;
    end
    if ({pll_m0, pll_n, pll_p, pll_chstby} !== prevDiv) begin
      checkOutput("div_change_only_in_stby", pll_stby, 1);
      checkOutput("div_chstby0_zero", pll_chstby[0], 0);
    end
    if (seen) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, want none",
                 kind, cyc);
      end else begin
        e = sbQueue.pop_front();
        checkOutput($sformatf("event_kind_due_%0d", e.cyc), kind, e.kind);
        checkOutput($sformatf("event_cycle_kind_%0d", e.kind), cyc, e.cyc);
        if (kind == EV_LOST) begin
          checkOutput("lost_cnt_at_pulse", lost_cnt, e.data);
          checkOutput("lost_with_locked_low", locked, 0);
          checkOutput("lost_with_clk_sel_low", clk_sel, 0);
        end else if (kind == EV_LOCK) begin
          checkOutput("lock_with_clk_sel_high", clk_sel, 1);
        end
      end
    end
  endtask

  // Scoreboard monitor, sampling half a cycle away from the active edge.
  always @(negedge clk) begin
    monitorStep();
    prevLocked <= locked;
    prevFail   <= fail;
    prevDiv    <= {pll_m0, pll_n, pll_p, pll_chstby};
  end

  initial begin
    int c;
    int pat [6];
    bit expStby;
    pat = '{1, 1, 0, 1, 1, 1};

    reset_l    = 1'b0;
    en         = 1'b0;
    plock      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_m0     = 1'b0;
    cfg_n      = '0;
    cfg_p      = '0;
    cfg_chstby = '0;

    waitCycles(3);
    checkResetValues("reset");
    reset_l = 1'b1;
    @(negedge clk);

    // Clean lock with plock already high: synchroniser has settled during
    // standby, so lock follows three settle cycles after standby drops.
    c     = cyc;
    en    = 1'b1;
    plock = 1'b1;
    expectEvent(EV_LOCK, c + 8, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stby_hold_%0d", k), pll_stby, 1);
    end
    @(negedge clk);
    checkOutput("stby_released", pll_stby, 0);
    waitUntil(c + 8);
    checkOutput("clean_locked", locked, 1);
    checkOutput("clean_cfg_ready", cfg_ready, 1);
    @(negedge clk);

    // Single loss of lock: plock low for 5 cycles.
    c     = cyc;
    plock = 1'b0;
    expectEvent(EV_LOST, c + 3, 1);
    expectEvent(EV_LOCK, c + 11, 0);
    waitCycles(5);
    plock = 1'b1;
    waitUntil(c + 11);
    checkOutput("lost_cnt_one", lost_cnt, 1);
    @(negedge clk);

    // Push the loss counter well past saturation.
    for (int i = 0; i < 256; i++) begin
      c     = cyc;
      plock = 1'b0;
      expectEvent(EV_LOST, c + 3, (i + 2 > 255) ? 255 : i + 2);
      expectEvent(EV_LOCK, c + 11, 0);
      waitCycles(5);
      plock = 1'b1;
      waitUntil(c + 11);
    end
    checkOutput("lost_cnt_saturated", lost_cnt, 255);
    @(negedge clk);

    // Reconfigure while running.
    c = cyc;
    checkOutput("run_cfg_ready", cfg_ready, 1);
    expectEvent(EV_LOCK, c + 8, 0);
    applyStimulus(1'b0, 4'd5, 12'h132, 3'b100);
    checkOutput("recfg_clk_sel_drop", clk_sel, 0);
    checkOutput("recfg_locked_drop", locked, 0);
    checkOutput("recfg_stby", pll_stby, 1);
    checkOutput("recfg_cfg_ready_busy", cfg_ready, 0);
    checkOutput("recfg_n_not_yet", pll_n, 7);
    @(negedge clk);
    checkOutput("recfg_n_loaded", pll_n, 5);
    checkOutput("recfg_p_loaded", pll_p, 12'h132);
    checkOutput("recfg_chstby_loaded", pll_chstby, 3'b100);
    checkOutput("recfg_m0_loaded", pll_m0, 0);
    checkOutput("recfg_stby_during_load", pll_stby, 1);
    waitUntil(c + 9);

    // Glitch filter: pattern 1,1,0,1,1,1 starting as WAIT_LOCK is entered.
    c     = cyc;
    plock = 1'b0;
    expectEvent(EV_LOST, c + 3, 255);
    expectEvent(EV_LOCK, c + 16, 0);
    waitUntil(c + 8);
    for (int k = 0; k < 6; k++) begin
      plock = (pat[k] != 0);
      @(negedge clk);
    end
    waitUntil(c + 13);
    checkOutput("glitch_no_early_lock", locked, 0);
    waitUntil(c + 17);

    // Timeout twice then FAIL; a cfg transfer restarts sequencing.
    c     = cyc;
    plock = 1'b0;
    expectEvent(EV_LOST, c + 3, 255);
    expectEvent(EV_FAIL, c + 44, 0);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      expStby = !((k <= 2) || (k >= 8 && k <= 23) || (k >= 28 && k <= 43));
      checkOutput($sformatf("timeout_stby_%0d", k), pll_stby, expStby);
      checkOutput($sformatf("timeout_fail_%0d", k), fail, (k >= 44));
    end
    c = cyc;
    checkOutput("fail_cfg_ready", cfg_ready, 1);
    plock = 1'b1;
    expectEvent(EV_LOCK, c + 8, 0);
    applyStimulus(1'b1, 4'd6, 12'h111, 3'b111);
    checkOutput("fail_cleared", fail, 0);
    checkOutput("fail_restart_stby", pll_stby, 1);
    checkOutput("fail_restart_clk_sel", clk_sel, 0);
    @(negedge clk);
    checkOutput("fail_restart_n", pll_n, 6);
    checkOutput("fail_restart_chstby", pll_chstby, 3'b110);
    waitUntil(c + 9);

    // en dropped while waiting for lock.
    c     = cyc;
    plock = 1'b0;
    expectEvent(EV_LOST, c + 3, 255);
    waitUntil(c + 9);
    checkOutput("wait_lock_stby", pll_stby, 0);
    checkOutput("wait_lock_cfg_ready", cfg_ready, 0);
    en = 1'b0;
    @(negedge clk);
    checkOutput("en_off_stby", pll_stby, 1);
    checkOutput("en_off_cfg_ready", cfg_ready, 1);
    checkOutput("en_off_clk_sel", clk_sel, 0);
    checkOutput("en_off_locked", locked, 0);
    waitCycles(2);
    checkOutput("idle_hold_stby", pll_stby, 1);

    // plock rising as standby drops: two synchroniser plus three settle
    // cycles, then an asynchronous reset while running.
    c  = cyc;
    en = 1'b1;
    expectEvent(EV_LOCK, c + 10, 0);
    waitUntil(c + 5);
    checkOutput("relock_stby_fall", pll_stby, 0);
    plock = 1'b1;
    waitUntil(c + 12);
    checkOutput("relock_running", locked, 1);
    #2 reset_l = 1'b0;
    #1 checkResetValues("async_reset");
    en    = 1'b0;
    plock = 1'b0;
    waitCycles(2);
    checkOutput("sb_drain", sbQueue.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
